// File: rtl/regfile_sbx.sv
// Multi-port integer register file with a per-register counting scoreboard.
// Reads are combinational with write-through bypass; each register tracks how
// many issued writes are still outstanding so WAW chains resolve correctly.
module regfile_sbx #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 4,
    parameter int unsigned NWR  = 2,
    parameter int unsigned CNTW = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    output logic                 iss_ready,
    input  logic [NWR-1:0]       wb_en,
    input  logic [NWR*AW-1:0]    wb_addr,
    input  logic [NWR*XLEN-1:0]  wb_data,
    output logic [NREG-1:0]      pending,
    output logic                 sb_err
);

    // Counter arithmetic width: wide enough for cnt + 1 and for NWR decrements.
    localparam int unsigned CW = CNTW + $clog2(NWR + 1);
    localparam logic [CNTW-1:0] CntMax = {CNTW{1'b1}};

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [CNTW-1:0] cnt_q  [NREG];
    logic [CNTW-1:0] cnt_d  [NREG];
    logic            sb_err_q;
    logic            sb_err_d;

    // Per-register view of this cycle's write-back traffic.
    logic [NREG-1:0] wr_hit;
    logic [XLEN-1:0] wr_val  [NREG];
    logic [CW-1:0]   dec_cnt [NREG];

    logic            iss_acc;
    logic [NREG-1:0] iss_hit;

    // Decode write-back ports per register; ascending scan lets higher ports win.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            wr_hit[r]  = 1'b0;
            wr_val[r]  = '0;
            dec_cnt[r] = '0;
        end
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wb_en[j]) begin
                wr_hit[wb_addr[j*AW +: AW]]  = 1'b1;
                wr_val[wb_addr[j*AW +: AW]]  = wb_data[j*XLEN +: XLEN];
                dec_cnt[wb_addr[j*AW +: AW]] = dec_cnt[wb_addr[j*AW +: AW]] + CW'(1);
            end
        end
    end

    // Issue handshake: blocked only by the registered counter being saturated.
    always_comb begin
        iss_ready = (iss_rd == '0) || (cnt_q[iss_rd] != CntMax);
        iss_acc   = iss_valid && iss_ready;
        iss_hit   = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            iss_hit[r] = iss_acc && (iss_rd == AW'(r));
        end
    end

    // Read ports: x0 is zero, otherwise bypass from write-back, else storage.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (rd_addr[i*AW +: AW] != '0) begin
                if (wr_hit[rd_addr[i*AW +: AW]]) begin
                    rd_data[i*XLEN +: XLEN] = wr_val[rd_addr[i*AW +: AW]];
                end else begin
                    rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
                end
                // Busy ignores the current issue so the final write-back frees operands.
                rd_busy[i] = CW'(cnt_q[rd_addr[i*AW +: AW]]) > dec_cnt[rd_addr[i*AW +: AW]];
            end
        end
    end

    // Next-state for storage, counters and the sticky underflow flag.
    always_comb begin
        sb_err_d = sb_err_q;
        for (int unsigned r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
            cnt_d[r]  = cnt_q[r];
        end
        regs_d[0] = '0;
        cnt_d[0]  = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (wr_hit[r]) begin
                regs_d[r] = wr_val[r];
            end
            // More write-backs than outstanding writes: clamp to zero and flag it.
            if (dec_cnt[r] > (CW'(cnt_q[r]) + CW'(iss_hit[r]))) begin
                cnt_d[r] = '0;
                sb_err_d = 1'b1;
            end else begin
                cnt_d[r] = CNTW'(CW'(cnt_q[r]) + CW'(iss_hit[r]) - dec_cnt[r]);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

    // Pending flags come straight from registered counters.
    always_comb begin
        pending = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            pending[r] = (cnt_q[r] != '0);
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_sbx.sv
// Self-checking bench for regfile_sbx: a table of per-cycle vectors with
// hand-derived expectations, pushed to a scoreboard queue when driven and
// popped/compared mid-cycle, plus an asynchronous reset sequence.
module tb_regfile_sbx;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 4;
    localparam int unsigned NWR  = 2;
    localparam int unsigned AW   = 5;

    logic                 clk;
    logic                 rst_n;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic                 iss_ready;
    logic [NWR-1:0]       wb_en;
    logic [NWR*AW-1:0]    wb_addr;
    logic [NWR*XLEN-1:0]  wb_data;
    logic [NREG-1:0]      pending;
    logic                 sb_err;

    regfile_sbx #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .CNTW (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .pending   (pending),
        .sb_err    (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        iv;
        logic [4:0]  ir;
        logic [1:0]  we;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [63:0] e0;
        logic [63:0] e1;
        logic [1:0]  eb;
        logic        er;
        logic [31:0] ep;
        logic        ee;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(string n, logic iv, logic [4:0] ir, logic [1:0] we,
                                logic [4:0] a0, logic [63:0] d0, logic [4:0] a1,
                                logic [63:0] d1, logic [4:0] r0, logic [4:0] r1,
                                logic [63:0] e0, logic [63:0] e1, logic [1:0] eb,
                                logic er, logic [31:0] ep, logic ee);
        vec_t v;
        v.name = n; v.iv = iv; v.ir = ir; v.we = we;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1;
        v.eb = eb; v.er = er; v.ep = ep; v.ee = ee;
        return v;
    endfunction

    task automatic drive(vec_t v);
        iss_valid = v.iv;
        iss_rd    = v.ir;
        wb_en     = v.we;
        wb_addr   = {v.a1, v.a0};
        wb_data   = {v.d1, v.d0};
        rd_addr   = {v.r1, v.r0, v.r1, v.r0};
    endtask

    task automatic check(vec_t e);
        logic [63:0] exp_d;
        logic [3:0]  exp_b;
        n_vec++;
        for (int p = 0; p < 4; p++) begin
            exp_d = (p % 2 == 0) ? e.e0 : e.e1;
            if (rd_data[p*64 +: 64] !== exp_d) begin
                $display("FAIL %s rd_data[%0d]: got %h want %h", e.name, p,
                         rd_data[p*64 +: 64], exp_d);
                n_err++;
            end
        end
        exp_b = {e.eb[1], e.eb[0], e.eb[1], e.eb[0]};
        if (rd_busy !== exp_b) begin
            $display("FAIL %s rd_busy: got %b want %b", e.name, rd_busy, exp_b);
            n_err++;
        end
        if (iss_ready !== e.er) begin
            $display("FAIL %s iss_ready: got %b want %b", e.name, iss_ready, e.er);
            n_err++;
        end
        if (pending !== e.ep) begin
            $display("FAIL %s pending: got %h want %h", e.name, pending, e.ep);
            n_err++;
        end
        if (sb_err !== e.ee) begin
            $display("FAIL %s sb_err: got %b want %b", e.name, sb_err, e.ee);
            n_err++;
        end
    endtask

    // Drive just after the rising edge, compare at the falling edge.
    task automatic apply(vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        check(exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        rst_n     = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        wb_en     = '0;
        wb_addr   = '0;
        wb_data   = '0;
        rd_addr   = '0;
        #12 rst_n = 1'b1;

        //        name         iv ir  we     a0  d0          a1  d1          r0  r1  e0          e1        eb     er  ep          ee
        tbl.push_back(mk("reset_state", 0, 0, 2'b00, 0, 0, 0, 0, 5, 0, 0, 0, 2'b00, 1, 32'h0, 0));
        tbl.push_back(mk("iss_x5",      1, 5, 2'b00, 0, 0, 0, 0, 5, 3, 0, 0, 2'b00, 1, 32'h0, 0));
        tbl.push_back(mk("wb_x5",       0, 5, 2'b01, 5, 64'h1234, 0, 0, 5, 5,
                         64'h1234, 64'h1234, 2'b00, 1, 32'h20, 0));
        tbl.push_back(mk("rd_x5",       0, 0, 2'b00, 0, 0, 0, 0, 5, 0, 64'h1234, 0, 2'b00, 1, 32'h0, 0));
        tbl.push_back(mk("iss_x7_a",    1, 7, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0, 2'b00, 1, 32'h0, 0));
        tbl.push_back(mk("iss_x7_b",    1, 7, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0, 2'b01, 1, 32'h80, 0));
        tbl.push_back(mk("wb_x7_dual",  0, 0, 2'b11, 7, 64'hAAAA, 7, 64'hBBBB, 7, 0,
                         64'hBBBB, 0, 2'b00, 1, 32'h80, 0));
        tbl.push_back(mk("rd_x7",       0, 0, 2'b00, 0, 0, 0, 0, 7, 3, 64'hBBBB, 0, 2'b00, 1, 32'h0, 0));
        tbl.push_back(mk("wb_x0",       0, 0, 2'b01, 0, 64'hDEAD, 0, 0, 0, 7,
                         0, 64'hBBBB, 2'b00, 1, 32'h0, 0));
        tbl.push_back(mk("rd_x0",       0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 32'h0, 0));
        tbl.push_back(mk("iss_x3_1",    1, 3, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0, 2'b00, 1, 32'h0, 0));
        tbl.push_back(mk("iss_x3_2",    1, 3, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0, 2'b01, 1, 32'h8, 0));
        tbl.push_back(mk("iss_x3_3",    1, 3, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0, 2'b01, 1, 32'h8, 0));
        tbl.push_back(mk("iss_x3_full", 1, 3, 2'b00, 0, 0, 0, 0, 3, 0, 0, 0, 2'b01, 0, 32'h8, 0));
        tbl.push_back(mk("wb_x3_a_sat", 1, 3, 2'b01, 3, 64'h31, 0, 0, 3, 0,
                         64'h31, 0, 2'b01, 0, 32'h8, 0));
        tbl.push_back(mk("wb_x3_b",     0, 3, 2'b10, 0, 0, 3, 64'h32, 3, 0,
                         64'h32, 0, 2'b01, 1, 32'h8, 0));
        tbl.push_back(mk("wb_x3_last",  0, 3, 2'b01, 3, 64'h33, 0, 0, 3, 0,
                         64'h33, 0, 2'b00, 1, 32'h8, 0));
        tbl.push_back(mk("rd_x3",       0, 0, 2'b00, 0, 0, 0, 0, 3, 0, 64'h33, 0, 2'b00, 1, 32'h0, 0));
        tbl.push_back(mk("iss_x9",      1, 9, 2'b00, 0, 0, 0, 0, 9, 0, 0, 0, 2'b00, 1, 32'h0, 0));
        tbl.push_back(mk("iss_wb_x9",   1, 9, 2'b01, 9, 64'h55, 0, 0, 9, 0,
                         64'h55, 0, 2'b00, 1, 32'h200, 0));
        tbl.push_back(mk("rd_x9",       0, 0, 2'b00, 0, 0, 0, 0, 9, 0, 64'h55, 0, 2'b01, 1, 32'h200, 0));
        tbl.push_back(mk("iss_x4_1",    1, 4, 2'b00, 0, 0, 0, 0, 4, 9, 0, 64'h55, 2'b10, 1, 32'h200, 0));
        tbl.push_back(mk("iss_x4_2",    1, 4, 2'b00, 0, 0, 0, 0, 4, 0, 0, 0, 2'b01, 1, 32'h210, 0));
        tbl.push_back(mk("wb_x4_dual",  0, 0, 2'b11, 4, 64'h40, 4, 64'h41, 4, 0,
                         64'h41, 0, 2'b00, 1, 32'h210, 0));
        tbl.push_back(mk("rd_x4",       0, 0, 2'b00, 0, 0, 0, 0, 4, 9,
                         64'h41, 64'h55, 2'b10, 1, 32'h200, 0));
        tbl.push_back(mk("wb_x12_under", 0, 0, 2'b10, 0, 0, 12, 64'hC0FFEE, 12, 4,
                         64'hC0FFEE, 64'h41, 2'b00, 1, 32'h200, 0));
        tbl.push_back(mk("rd_x12",      0, 0, 2'b00, 0, 0, 0, 0, 12, 5,
                         64'hC0FFEE, 64'h1234, 2'b00, 1, 32'h200, 1));
        tbl.push_back(mk("iss_x5_again", 1, 5, 2'b00, 0, 0, 0, 0, 5, 0,
                         64'h1234, 0, 2'b00, 1, 32'h200, 1));
        tbl.push_back(mk("err_sticky",  0, 0, 2'b00, 0, 0, 0, 0, 5, 9,
                         64'h1234, 64'h55, 2'b11, 1, 32'h220, 1));

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k]);
        end

        // Asynchronous reset asserted mid-cycle; outputs must clear with no edge.
        @(posedge clk);
        #1;
        rv = mk("async_reset", 0, 5, 2'b00, 0, 0, 0, 0, 5, 12, 0, 0, 2'b00, 1, 32'h0, 0);
        drive(rv);
        #2;
        rst_n = 1'b0;
        exp_q.push_back(rv);
        #1;
        check(exp_q.pop_front());
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        apply(mk("post_reset", 0, 5, 2'b00, 0, 0, 0, 0, 5, 9, 0, 0, 2'b00, 1, 32'h0, 0));
        apply(mk("post_reset_iss", 1, 9, 2'b00, 0, 0, 0, 0, 9, 12, 0, 0, 2'b00, 1, 32'h0, 0));
        apply(mk("post_reset_pend", 0, 0, 2'b00, 0, 0, 0, 0, 9, 0, 0, 0, 2'b01, 1, 32'h200, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sbx.md
# regfile_sbx

Parametrised multi-port integer register file with a counting scoreboard, for the OSYRYS-64 core and its NPU coprocessor. It serves NRD combinational read ports with same-cycle write-through bypass and NWR write-back ports. Each register keeps a counter of outstanding writes, so multiple in-flight writes to one register (WAW) are tracked correctly, which a single pending bit cannot do. It sits between issue/decode, the execution units (ALU, LSU, NPU) and the hazard detection unit.

## Interface
Parameters:
- XLEN, 64, register width in bits.
- NREG, 32, number of registers; power of two, ≥ 2; register 0 is hardwired to zero.
- NRD, 4, number of read ports (CPU rs1/rs2 plus NPU/external ports).
- NWR, 2, number of write-back ports; a higher index has higher priority.
- CNTW, 2, width of each pending counter; at most 2^CNTW−1 outstanding writes per register.
- AW, $clog2(NREG), derived address width; not overridable.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data per port (combinational).
- rd_busy  out  NRD  per read port: the addressed register still has a write outstanding after this cycle.
- iss_valid  in  1  issue of an instruction that will write iss_rd.
- iss_rd  in  AW  destination register of the issued instruction.
- iss_ready  out  1  the issue is accepted this cycle.
- wb_en  in  NWR  write-back enables.
- wb_addr  in  NWR*AW  write-back addresses.
- wb_data  in  NWR*XLEN  write-back data.
- pending  out  NREG  bit r = (cnt[r] != 0), taken from registered state.
- sb_err  out  1  sticky flag: a write-back arrived for a register whose counter was 0.

## Operation
- Storage: regs[NREG] each XLEN bits wide, and cnt[NREG] each CNTW bits wide. Register 0 is never written, and cnt[0] stays 0.
- Read, port i, address a:
  - If a == 0, rd_data is 0.
  - Otherwise, if any wb_en[j] with wb_addr[j] == a, rd_data is wb_data of the highest such j (bypass).
  - Otherwise, rd_data is regs[a].
- Write: for each register r ≠ 0, the highest-index enabled port with wb_addr == r writes its data. Other ports targeting the same register are dropped.
- Issue handshake:
  - iss_ready = (iss_rd == 0) or (cnt[iss_rd] != 2^CNTW−1).
  - An issue is accepted when iss_valid && iss_ready.
  - An accepted issue to x0 has no effect.
- Counter update, per register r ≠ 0, each cycle:
  - inc = accepted issue to r (0 or 1).
  - dec = number of enabled write-back ports addressing r (0..NWR).
  - If dec > cnt[r] + inc: cnt[r] becomes 0 and sb_err is set.
  - Otherwise: cnt[r] becomes cnt[r] + inc − dec.
  - Counter arithmetic is done at CNTW+$clog2(NWR+1) bits, so no intermediate value wraps.
- rd_busy[i]:
  - 0 if rd_addr[i] == 0.
  - Otherwise 1 if (cnt[a] − dec[a]) > 0, computed without the current issue. This means operands are released in the same cycle as the final write-back.
- sb_err is cleared only by reset.

## Timing
- Reset (asynchronous assert, any cycle, including mid-operation):
  - All regs, all cnt and sb_err go to 0.
  - Resulting outputs: rd_data = 0, pending = 0, rd_busy = 0, iss_ready = 1.
  - Writes and issues in flight are discarded.
- Read latency is 0 cycles, including bypass.
- Write latency: data is visible through regs on the cycle after wb_en, and through bypass in the same cycle.
- pending updates one cycle after the issue or write-back. rd_busy reflects write-backs in the same cycle.
- Simultaneous issue and write-back to the same register: counter net change is 0. The data is written, and pending stays 1.
- Saturation: when cnt[r] is at its maximum, iss_ready drops for r. If a write-back to r happens in the same cycle, iss_ready still stays low, because it is based on registered cnt only.

## Test plan
- Reset: write x5 = 0x1234, then pulse rst_n low asynchronously between clock edges -> rd_data(x5) = 0, pending = 0, sb_err = 0 immediately, with no clock edge needed.
- Bypass and priority: wb_en = 2'b11, both ports address x7, data A = 0xAAAA and B = 0xBBBB -> rd_data(x7) = 0xBBBB in the same cycle and after the edge. A write to x0 reads back as 0.
- WAW counting: issue x3 three times (cnt = 3), then a fourth issue -> iss_ready = 0. One write-back -> cnt = 2, pending[3] = 1, rd_busy(x3) = 1. Two more write-backs -> rd_busy = 0 in the cycle of the last write-back, pending[3] = 0 on the next cycle.
- Simultaneous events: x9 has cnt = 1, and issue x9 plus write-back x9 = 0x55 happen in the same cycle -> cnt stays 1, regs[9] = 0x55, pending[9] = 1.
- Underflow: write-back to x12 with cnt = 0 -> data is written, cnt stays 0, and sb_err = 1 persists until reset.
- Dual write-back to one register, NWR = 2: x4 has cnt = 2, both ports write x4 -> cnt = 0, data from port 1 is kept, sb_err stays 0.
